// File: rtl/decodificador_varredura_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
// Helpers work on a fixed maximum width; callers zero-extend and truncate to their own SEL_W.
package decodificador_pkg;

  localparam int SEL_W_PADRAO = 3;
  localparam int SEL_W_MAX    = 6;
  localparam int NUM_MAX      = 2 ** SEL_W_MAX;

  typedef enum logic {MODO_MANUAL = 1'b0, MODO_VARREDURA = 1'b1} modo_e;

  // found sits in the LSB so truncating the struct keeps it.
  typedef struct packed {
    logic [SEL_W_MAX-1:0] idx;
    logic                 found;
  } busca_t;

  function automatic logic [NUM_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] i);
    logic [NUM_MAX-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Walks down from the farthest candidate so the nearest enabled channel wins.
  // Offset num_out lands back on idx, which covers a single enabled channel.
  function automatic busca_t proximo_habilitado(input logic [SEL_W_MAX-1:0] i,
                                                input logic [NUM_MAX-1:0]   m,
                                                input int                   num_out);
    busca_t               r;
    logic [SEL_W_MAX-1:0] cand;
    r = '0;
    for (int k = NUM_MAX; k >= 1; k--) begin
      if (k <= num_out) begin
        cand = SEL_W_MAX'((int'(i) + k) & (num_out - 1));
        if (m[cand]) begin
          r.idx   = cand;
          r.found = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decodificador_varredura_if.sv
// Control and output bundle of the scanning decoder.
interface decodificador_varredura_if #(parameter int SEL_W = 3);
  localparam int NUM_OUT = 2 ** SEL_W;

  logic               en;
  logic               modo;
  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] mask;
  logic [NUM_OUT-1:0] saida;
  logic [SEL_W-1:0]   idx;
  logic               volta;

  modport master (output en, modo, sel, mask, input saida, idx, volta);
  modport slave  (input en, modo, sel, mask, output saida, idx, volta);
endinterface

// File: rtl/decodificador_varredura_prescaler.sv
// Scan step prescaler: counts 0..PRESCALE-1, sync clear, hold when disabled.
module prescaler_varredura #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa_i,
  input  logic habilita_i,
  output logic tc_o
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fim_w;

  assign fim_w = (cnt_q == CNT_W'(PRESCALE - 1));
  assign tc_o  = habilita_i && !limpa_i && fim_w;

  always_comb begin
    cnt_d = cnt_q;
    if (limpa_i)         cnt_d = '0;
    else if (habilita_i) cnt_d = fim_w ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/decodificador_varredura.sv
// Registered binary-to-one-hot decoder with automatic channel scan for digit multiplexing.
// Build option SAIDA_ATIVA_BAIXA_EN inverts saida (active-low, idle all ones).
module decodificador_varredura
  import decodificador_pkg::*;
#(
  parameter int SEL_W    = SEL_W_PADRAO,
  parameter int PRESCALE = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  decodificador_varredura_if.slave bus
);
  localparam int NUM_OUT = 2 ** SEL_W;

  logic [NUM_OUT-1:0] saida_q, saida_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               volta_q, volta_d;
  logic [SEL_W-1:0]   prox_w;
  logic               achou_w;
  logic               tc_w;
  modo_e              modo_w;

  assign modo_w = modo_e'(bus.modo);

  prescaler_varredura #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .limpa_i    (modo_w == MODO_MANUAL),
    .habilita_i (bus.en),
    .tc_o       (tc_w)
  );

  always_comb begin
    {prox_w, achou_w} = (SEL_W + 1)'(proximo_habilitado(SEL_W_MAX'(idx_q),
                                                        NUM_MAX'(bus.mask), NUM_OUT));
  end

  always_comb begin
    idx_d   = idx_q;
    saida_d = '0;
    volta_d = 1'b0;
    if (bus.en) begin
      if (modo_w == MODO_MANUAL) begin
        idx_d = bus.sel;
      end else if (tc_w && achou_w) begin
        idx_d   = prox_w;
        volta_d = (prox_w <= idx_q);
      end
      // Output tracks the new index, gated by its own mask bit.
      if (bus.mask[idx_d]) saida_d = NUM_OUT'(onehot(SEL_W_MAX'(idx_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q <= '0;
      idx_q   <= '0;
      volta_q <= 1'b0;
    end else begin
      saida_q <= saida_d;
      idx_q   <= idx_d;
      volta_q <= volta_d;
    end
  end

`ifdef SAIDA_ATIVA_BAIXA_EN
  assign bus.saida = ~saida_q;
`else
  assign bus.saida = saida_q;
`endif
  assign bus.idx   = idx_q;
  assign bus.volta = volta_q;
endmodule

// File: tb/tb_decodificador_varredura.sv
// Directed bench: dut4 scans with PRESCALE=4, dut1 with PRESCALE=1; both share the same stimulus.
module tb_decodificador_varredura;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       modo = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] mask = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  decodificador_varredura_if #(.SEL_W(3)) bus4 ();
  decodificador_varredura_if #(.SEL_W(3)) bus1 ();

  assign bus4.en = en;  assign bus4.modo = modo;  assign bus4.sel = sel;  assign bus4.mask = mask;
  assign bus1.en = en;  assign bus1.modo = modo;  assign bus1.sel = sel;  assign bus1.mask = mask;

  decodificador_varredura #(.SEL_W(3), .PRESCALE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  decodificador_varredura #(.SEL_W(3), .PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Expected pin value for an active-high one-hot pattern.
  function automatic logic [7:0] ex(input logic [7:0] v);
`ifdef SAIDA_ATIVA_BAIXA_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; modo = 1'b0; sel = 3'd0; mask = 8'hFF;
    #12;
    checks++;
    if (bus4.saida !== ex(8'h00) || bus4.idx !== 3'd0 || bus4.volta !== 1'b0) begin
      errors++;
      $display("FAIL reset: saida=%b idx=%0d volta=%b, required saida=%b idx=0 volta=0",
               bus4.saida, bus4.idx, bus4.volta, ex(8'h00));
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [2:0] s_tab [3] = '{3'd5, 3'd5, 3'd2};
    logic [7:0] m_tab [3] = '{8'hFF, 8'hDF, 8'hFF};
    logic [7:0] e_tab [3] = '{8'b0010_0000, 8'h00, 8'b0000_0100};
    modo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = s_tab[i]; mask = m_tab[i];
      @(negedge clk);
      checks++;
      if (bus4.saida !== ex(e_tab[i]) || bus4.idx !== s_tab[i] || bus4.volta !== 1'b0) begin
        errors++;
        $display("FAIL manual[%0d]: saida=%b idx=%0d volta=%b, required saida=%b idx=%0d volta=0",
                 i, bus4.saida, bus4.idx, bus4.volta, ex(e_tab[i]), s_tab[i]);
      end
    end
  endtask

  task automatic test_scan_full();
    logic [2:0] e_idx;
    logic       e_volta;
    modo = 1'b0; sel = 3'd0; mask = 8'hFF;
    @(negedge clk);
    modo = 1'b1; e_idx = 3'd0;
    for (int s = 0; s < 9; s++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        e_volta = (c == 4) && (e_idx == 3'd7);
        if (c == 4) e_idx = e_idx + 3'd1;
        checks++;
        if (bus4.idx !== e_idx || bus4.volta !== e_volta || bus4.saida !== ex(8'b1 << e_idx)) begin
          errors++;
          $display("FAIL scan_full s%0d c%0d: idx=%0d volta=%b saida=%b, required idx=%0d volta=%b saida=%b",
                   s, c, bus4.idx, bus4.volta, bus4.saida, e_idx, e_volta, ex(8'b1 << e_idx));
        end
      end
    end
  endtask

  task automatic test_sparse();
    logic [2:0] seq [6] = '{3'd2, 3'd7, 3'd0, 3'd2, 3'd7, 3'd0};
    modo = 1'b0; sel = 3'd0; mask = 8'b1000_0101;
    @(negedge clk);
    modo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.idx !== seq[i] || bus1.volta !== (seq[i] == 3'd0) || bus1.saida !== ex(8'b1 << seq[i])) begin
        errors++;
        $display("FAIL sparse[%0d]: idx=%0d volta=%b saida=%b, required idx=%0d volta=%b",
                 i, bus1.idx, bus1.volta, bus1.saida, seq[i], (seq[i] == 3'd0));
      end
    end
    mask = 8'b0001_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      // first step is 0 -> 4 (no wrap), then 4 -> 4 wraps every step
      if (bus1.idx !== 3'd4 || bus1.volta !== (i != 0) || bus1.saida !== ex(8'b0001_0000)) begin
        errors++;
        $display("FAIL single[%0d]: idx=%0d volta=%b saida=%b, required idx=4 volta=%b saida=%b",
                 i, bus1.idx, bus1.volta, bus1.saida, (i != 0), ex(8'b0001_0000));
      end
    end
  endtask

  task automatic test_empty_mask();
    modo = 1'b0; sel = 3'd6; mask = 8'hFF;
    @(negedge clk);
    modo = 1'b1; mask = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus4.idx !== 3'd6 || bus4.volta !== 1'b0 || bus4.saida !== ex(8'h00)) begin
        errors++;
        $display("FAIL empty[%0d]: idx=%0d volta=%b saida=%b, required idx=6 volta=0 saida=%b",
                 i, bus4.idx, bus4.volta, bus4.saida, ex(8'h00));
      end
    end
  endtask

  task automatic test_mid_mask();
    logic [2:0] e_idx [3] = '{3'd2, 3'd2, 3'd3};
    logic [7:0] e_sd  [3] = '{8'h00, 8'h00, 8'b0000_1000};
    modo = 1'b0; sel = 3'd2; mask = 8'hFF;
    @(negedge clk);
    modo = 1'b1;
    @(negedge clk);
    mask = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus4.idx !== e_idx[i] || bus4.saida !== ex(e_sd[i]) || bus4.volta !== 1'b0) begin
        errors++;
        $display("FAIL mid_mask[%0d]: idx=%0d saida=%b volta=%b, required idx=%0d saida=%b volta=0",
                 i, bus4.idx, bus4.saida, bus4.volta, e_idx[i], ex(e_sd[i]));
      end
    end
  endtask

  task automatic test_enable();
    logic [2:0] e_idx [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [7:0] e_sd  [5] = '{8'h00, 8'h00, 8'h00, 8'b0000_1000, 8'b0001_0000};
    modo = 1'b0; sel = 3'd3; mask = 8'hFF;
    @(negedge clk);
    modo = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      en = (i >= 3);
      @(negedge clk);
      checks++;
      if (bus4.idx !== e_idx[i] || bus4.saida !== ex(e_sd[i]) || bus4.volta !== 1'b0) begin
        errors++;
        $display("FAIL enable[%0d]: idx=%0d saida=%b volta=%b, required idx=%0d saida=%b volta=0",
                 i, bus4.idx, bus4.saida, bus4.volta, e_idx[i], ex(e_sd[i]));
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    en = 1'b1; modo = 1'b0; sel = 3'd5; mask = 8'hFF;
    @(negedge clk);
    modo = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.saida !== ex(8'h00) || bus4.idx !== 3'd0 || bus4.volta !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: saida=%b idx=%0d volta=%b, required saida=%b idx=0 volta=0",
               bus4.saida, bus4.idx, bus4.volta, ex(8'h00));
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus4.idx !== ((c == 4) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL first_step c%0d: idx=%0d, required %0d", c, bus4.idx, (c == 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_full();
    test_sparse();
    test_empty_mask();
    test_mid_mask();
    test_enable();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decodificador_varredura.md
Name: decodificador_varredura

Overview:
Parametrised registered binary-to-one-hot decoder, SEL_W inputs to 2**SEL_W outputs, with a built-in scan sequencer. In manual mode it registers a decode of an external select. In scan mode a prescaled counter steps through enabled channels automatically. It drives the digit-select lines of the multiplexed 7-segment display behind the BCD adder.

Parameters:
SEL_W, 3, width of select/index; NUM_OUT = 2**SEL_W outputs (localparam)
PRESCALE, 1000, clk cycles per scan step; legal range >= 1; 1 = step every cycle

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 forces outputs inactive and freezes counters
modo  input  1  0 = manual decode of sel, 1 = automatic scan
sel  input  SEL_W  manual-mode channel select
mask  input  NUM_OUT  channel enable mask; bit i = 1 means channel i may be driven
saida  output  NUM_OUT  registered one-hot channel select (all-zero when idle)
idx  output  SEL_W  registered index of current channel
volta  output  1  one-cycle pulse when scan wraps from highest enabled channel to lowest

Behaviour:
- Reset, asynchronous on rst_n low: saida=0, idx=0, volta=0, prescaler=0. Reset mid-scan aborts immediately. The first step after release occurs PRESCALE cycles later if modo=1.
- All outputs are flops. saida is always the decode of idx gated by mask[idx], en and the mode rules below. It is never more than one-hot.
- en=0: next cycle saida=0, volta=0. idx and prescaler hold. On en return, saida resumes from the held idx on the next cycle. The prescaler continues from its held value.
- Manual mode (modo=0), latency 1 cycle:
  - idx <= sel.
  - saida <= onehot(sel) if mask[sel], else 0.
  - volta=0. Prescaler held at 0.
- Scan mode (modo=1):
  - Prescaler counts 0..PRESCALE-1.
  - At terminal count it returns to 0 and a step occurs.
  - Step: idx <= next enabled channel after idx, searched upward modulo NUM_OUT, priority nearest. saida <= onehot(new idx).
  - volta=1 for that cycle if new idx <= old idx, i.e. the search crossed index NUM_OUT-1.
  - Single enabled channel: idx stays, volta pulses every step.
  - mask all zero: no step, idx holds, saida=0, volta=0.
  - Current idx becomes masked between steps: saida=0 from the next cycle. The next step advances normally from the held idx.
- Mode change 0 -> 1: prescaler cleared to 0, idx retains the last sel value, and saida follows the scan rules from the next cycle. Mode change 1 -> 0: manual rules apply immediately, with 1-cycle latency.
- sel, mask and modo are sampled every cycle. There is no handshake.

Optional Feature:
Macro SAIDA_ATIVA_BAIXA_EN.
- Defined: saida is inverted at the flop output for common-anode displays. Active channel = 0, idle = all ones, reset value all ones.
- Undefined: active-high as described above.
- idx and volta are unaffected either way.

Decomposition:
- Package decodificador_pkg:
  - localparam default SEL_W.
  - typedef enum logic {MODO_MANUAL, MODO_VARREDURA}.
  - Function onehot(idx) returning NUM_OUT bits.
  - Function proximo_habilitado(idx, mask) returning the next enabled index and a found flag.
- One sub-module: prescaler_varredura (counter 0..PRESCALE-1, synchronous clear, hold, terminal-count pulse). Everything else stays in the top.

Test Plan:
- Reset, then manual: modo=0, mask=8'hFF, sel=5 -> saida=8'b0010_0000, idx=5 one cycle later. sel=5 with mask[5]=0 -> saida=0, idx=5.
- Scan, full mask: PRESCALE=4, mask=8'hFF.
  - idx steps 0,1,...,7,0 every 4 cycles.
  - volta pulses exactly on the 7->0 step.
  - saida is one-hot at every cycle.
- Sparse mask: mask=8'b1000_0101, PRESCALE=1 -> idx sequence 0,2,7,0,2,...; volta on each 7->0 step. mask=8'b0001_0000 -> idx=4 held, volta every cycle.
- Empty mask and mid-scan masking:
  - mask=0 -> saida=0, idx frozen, volta=0.
  - Clearing mask[idx] mid-step -> saida=0 next cycle, then the scan resumes at the next enabled channel.
- en and reset mid-operation:
  - en=0 at idx=3, prescaler=2 -> saida=0, both held. en=1 -> saida=8'b0000_1000 next cycle, step 2 cycles later (PRESCALE=4).
  - rst_n pulse mid-scan -> immediate saida=0, idx=0.
- Macro build with SAIDA_ATIVA_BAIXA_EN: reset -> saida=8'hFF. Manual sel=2 -> saida=8'b1111_1011.
